// File: rtl/shared_mem_bus.sv
// Multi-master word-addressed RAM bus with round-robin arbitration and fixed wait states.
// Optional BUS_RANGE_CHK_EN: out-of-range accesses are dropped/flagged instead of aliasing.
module shared_mem_bus #(
  parameter int NUM_M       = 2,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_M-1:0]          Read,
  input  logic [NUM_M-1:0]          Write,
  input  logic [NUM_M*ADDR_W-1:0]   Addr,
  input  logic [NUM_M*DATA_W-1:0]   WrData,
  output logic [NUM_M*DATA_W-1:0]   RdData,
  output logic [NUM_M-1:0]          Waitreq,
  output logic                      ErrFlag
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [DATA_W-1:0] DEAD_WORD = DATA_W'(16'hDEAD);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [NUM_M-1:0]    ack_q;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [NUM_M-1:0]    req;
  logic                found;
  logic [PTR_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    idx;
  logic                oob;
  logic                final_access;
  logic [DATA_W-1:0]   rd_val;
  logic                unused_addr;

`ifdef BUS_RANGE_CHK_EN
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= (ADDR_W+1)'(DEPTH));
  endfunction
  assign oob = out_of_range(addr_q);
`else
  assign oob = 1'b0;
`endif

  assign req          = Read | Write;
  assign idx          = addr_q[IDX_W-1:0];
  assign final_access = (state == ACCESS) && (cnt == 4'd0);
  assign rd_val       = oob ? DEAD_WORD : mem[idx];
  assign Waitreq      = ~ack_q;
  assign unused_addr  = ^addr_q;

  // First requester at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    int cand;
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_M) cand = cand - NUM_M;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(cand);
      end
    end
  end

  // Request capture stage: address/data latched at grant, not reset.
  always_ff @(posedge Clock) begin
    if (state == IDLE && found) begin
      addr_q <= Addr[gnt_idx*ADDR_W +: ADDR_W];
      data_q <= WrData[gnt_idx*DATA_W +: DATA_W];
    end
  end

  // RAM commit stage: an async reset drops state to IDLE, so an aborted write never lands.
  always_ff @(posedge Clock) begin
    if (final_access && wr_q && !oob)
      mem[idx] <= data_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      ack_q  <= '0;
      rr_ptr <= '0;
      gnt_q  <= '0;
      wr_q   <= 1'b0;
      RdData <= '0;
`ifdef BUS_RANGE_CHK_EN
      ErrFlag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_q <= gnt_idx;
            wr_q  <= Write[gnt_idx];
            cnt   <= 4'(WAIT_STATES);
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!wr_q)
              RdData[gnt_q*DATA_W +: DATA_W] <= rd_val;
`ifdef BUS_RANGE_CHK_EN
            if (oob)
              ErrFlag <= 1'b1;
`endif
            ack_q[gnt_q] <= 1'b1;
            state        <= ACK;
          end
        end
        ACK: begin
          ack_q  <= '0;
          rr_ptr <= (int'(gnt_q) == NUM_M - 1) ? '0 : gnt_q + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BUS_RANGE_CHK_EN
  assign ErrFlag = 1'b0;
`endif

endmodule

// File: tb/tb_shared_mem_bus.sv
// Scoreboard bench for shared_mem_bus: drivers push expected completions, a monitor pops on each ack.
module tb_shared_mem_bus;

  localparam int WS = 1;
`ifdef BUS_RANGE_CHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  typedef struct {
    int          m;
    bit          rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic [1:0]  Read, Write, Waitreq;
  logic [31:0] Addr, WrData, RdData;
  logic        ErrFlag;

  logic [1:0]  p0_rd, p0_wq, p15_rd, p15_wq;
  logic [31:0] p0_rdata, p15_rdata;
  logic        p0_err, p15_err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_mem_bus #(.NUM_M(2), .DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(WS)) dut (
    .Clock(clk), .Reset(Reset), .Read(Read), .Write(Write), .Addr(Addr), .WrData(WrData),
    .RdData(RdData), .Waitreq(Waitreq), .ErrFlag(ErrFlag));

  shared_mem_bus #(.NUM_M(2), .DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(0)) u_ws0 (
    .Clock(clk), .Reset(Reset), .Read(p0_rd), .Write(2'b00), .Addr(32'h0), .WrData(32'h0),
    .RdData(p0_rdata), .Waitreq(p0_wq), .ErrFlag(p0_err));

  shared_mem_bus #(.NUM_M(2), .DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(15)) u_ws15 (
    .Clock(clk), .Reset(Reset), .Read(p15_rd), .Write(2'b00), .Addr(32'h0), .WrData(32'h0),
    .RdData(p15_rdata), .Waitreq(p15_wq), .ErrFlag(p15_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One transfer by master m; optionally pushes its own expectation with exact latency.
  task automatic xfer(input int m, input bit rd, input bit wr, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] exp_d, input bit push);
    int n;
    @(negedge clk);
    Read[m]            = rd;
    Write[m]           = wr;
    Addr[m*16 +: 16]   = a;
    WrData[m*16 +: 16] = d;
    if (push) q.push_back('{m, rd && !wr, exp_d, cyc + WS + 2});
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (Waitreq[m] === 1'b0) break;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: master %0d got no ack, expected ack within 100 cycles", m);
    end
    @(posedge clk);
    #1;
    Read[m]  = 1'b0;
    Write[m] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (Reset === 1'b0) begin
      for (int m = 0; m < 2; m++) begin
        if (Waitreq[m] === 1'b0) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: master %0d acked, expected no ack", m);
          end else begin
            mon_e = q.pop_front();
            chk("grant_master", 32'(m), 32'(mon_e.m));
            if (mon_e.rd) chk("rd_data", {16'h0, RdData[m*16 +: 16]}, {16'h0, mon_e.data});
            if (mon_e.cyc >= 0) chk("latency", 32'(cyc), 32'(mon_e.cyc));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1);
  end

  initial begin
    int c, n;
    Reset = 1'b1;
    Read = '0; Write = '0; Addr = '0; WrData = '0;
    p0_rd = '0; p15_rd = '0;
    repeat (2) @(negedge clk);
    chk("reset_waitreq", {30'h0, Waitreq}, 32'h3);
    chk("reset_rddata", RdData, 32'h0);
    chk("reset_errflag", {31'h0, ErrFlag}, 32'h0);
    Reset = 1'b0;

    // Known contents for later checks.
    xfer(0, 0, 1, 16'd9, 16'h0000, 16'h0, 1);
    xfer(0, 0, 1, 16'd0, 16'h5555, 16'h0, 1);
    xfer(0, 0, 1, 16'd5, 16'h1234, 16'h0, 1);
    xfer(0, 1, 0, 16'd5, 16'h0000, 16'h1234, 1);

    // Read and Write together: the write is performed.
    xfer(1, 1, 1, 16'd3, 16'h00AA, 16'h0, 1);
    xfer(1, 1, 0, 16'd3, 16'h0000, 16'h00AA, 1);

    // Contention: rr_ptr is 0 here, so grants alternate m0, m1.
    for (int i = 0; i < 4; i++) begin
      q.push_back('{0, 1'b1, 16'h1234, -1});
      q.push_back('{1, 1'b1, 16'h00AA, -1});
    end
    fork
      begin
        for (int i = 0; i < 4; i++) xfer(0, 1, 0, 16'd5, 16'h0, 16'h0, 0);
      end
      begin
        for (int i = 0; i < 4; i++) xfer(1, 1, 0, 16'd3, 16'h0, 16'h0, 0);
      end
    join

    // Out-of-range address 0x1000.
    xfer(0, 0, 1, 16'h1000, 16'hCAFE, 16'h0, 1);
    @(negedge clk);
    chk("errflag_set", {31'h0, ErrFlag}, {31'h0, RCHK});
    xfer(0, 1, 0, 16'h0000, 16'h0, RCHK ? 16'h5555 : 16'hCAFE, 1);
    xfer(0, 1, 0, 16'h1000, 16'h0, RCHK ? 16'hDEAD : 16'hCAFE, 1);
    xfer(1, 1, 0, 16'd5, 16'h0, 16'h1234, 1);
    @(negedge clk);
    chk("errflag_sticky", {31'h0, ErrFlag}, {31'h0, RCHK});

    // Wait-state extremes on the side instances.
    @(negedge clk);
    c = cyc; p0_rd = 2'b01; n = 0;
    while (p0_wq[0] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("latency_ws0", 32'(cyc - c), 32'd2);
    @(posedge clk); #1 p0_rd = 2'b00;
    @(negedge clk);
    c = cyc; p15_rd = 2'b10; n = 0;
    while (p15_wq[1] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("latency_ws15", 32'(cyc - c), 32'd17);
    @(posedge clk); #1 p15_rd = 2'b00;

    // Reset during the final ACCESS cycle of a write: the write must not land.
    @(negedge clk);
    Write[0] = 1'b1; Addr[15:0] = 16'd9; WrData[15:0] = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
    #1;
    chk("abort_waitreq", {30'h0, Waitreq}, 32'h3);
    chk("abort_errflag", {31'h0, ErrFlag}, 32'h0);
    chk("abort_rddata", RdData, 32'h0);
    Write[0] = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    xfer(0, 1, 0, 16'd9, 16'h0, 16'h0000, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
